seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the 4-digit BCD counter and takes that counter's packed 16-bit BCD `count` as its `bcd` input. It scans one digit per refresh slot, decodes BCD to active-low segments, and optionally blanks leading zeros. The input is snapshotted once per frame so a digit never tears mid-scan.

## Interface
Parameters:
- `REFRESH_DIV`, default 12500: clock cycles per digit slot (50 MHz gives 4 kHz per digit, 1 kHz per frame). Must be ≥ 2.
- `GUARD`, default 16: cycles at the start of each slot with all anodes off (anti-ghosting). Must satisfy 0 ≤ GUARD < REFRESH_DIV.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: system clock.
- `grst`  in  1: asynchronous active-high reset.
- `bcd`  in  16: packed BCD, {d3,d2,d1,d0}; d0 is the rightmost digit.
- `dp_en`  in  4: decimal-point enable per digit; bit i applies to digit i.
- `blank_lz`  in  1: 1 enables leading-zero blanking.
- `an`  out  4: anode selects, active-low; bit i drives digit i.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1: decimal point, active-low.
- `scan_tick`  out  1: one-cycle pulse at the start of each frame.

## Operation
- The prescaler `pres` counts 0..REFRESH_DIV-1 and wraps. The cycle in which `pres` equals REFRESH_DIV-1 is a tick.
- The digit index `idx` is 2 bits. On each tick it advances 3→0→1→2→3.
- Snapshot: on a tick where `idx` wraps 3→0, `snap_bcd` loads `bcd` and `snap_dp` loads `dp_en`, both sampled in that tick cycle. The outputs for digit 0 in the new slot use these freshly sampled values. All four digits of a frame come from one snapshot.
- Leading-zero blanking, computed from the snapshot:
  - blank3 = blank_lz & (d3==0)
  - blank2 = blank3 & (d2==0)
  - blank1 = blank2 & (d1==0)
  - Digit 0 is never blanked.
- Decode table (seg hex):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
  - Non-BCD nibble A–F→3F (segment g only, shown as "-").
  - Blanked digit→7F.
- `dp` = ~snap_dp[idx]. It is independent of blanking.
- `an` = 4'b1111 while `pres` < GUARD. Otherwise `an` = ~(1<<idx), exactly one bit low.
- `an`, `seg`, `dp` and `scan_tick` are all registered. They are computed from the next-state values of `pres` and `idx`, so they track those registers with no extra lag.
- `scan_tick` goes high for exactly one cycle after the edge at which `idx` becomes 0.

## Timing
- Reset values:
  - Internal: pres=0, idx=3, snap_bcd=0, snap_dp=0.
  - Outputs: an=4'b1111, seg=7'h7F, dp=1, scan_tick=0.
  - All apply asynchronously while `grst` is high.
- After `grst` falls, the first tick occurs in cycle REFRESH_DIV-1.
  - At that edge: idx→0, the snapshot loads, seg/dp show digit 0, scan_tick=1, an=1111.
  - If GUARD=0, an=1110 from that same edge.
- Within each slot, `an` is low for REFRESH_DIV-GUARD cycles.
- A frame is 4·REFRESH_DIV cycles. `scan_tick` period equals the frame length.
- Changes on `bcd` or `dp_en` are visible no earlier than the next frame start. Worst-case latency is 4·REFRESH_DIV cycles.
- `blank_lz` is applied live (not snapshotted). A change takes effect at the next slot boundary.
- `grst` asserted mid-slot:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - On release, the reset-release sequence above repeats.
- There are no handshakes. Inputs are assumed synchronous to `clk`.

## Test plan
Use REFRESH_DIV=8, GUARD=2.
- **Reset:** hold `grst`, then release. Required: an=F, seg=7F, dp=1, scan_tick=0 for 7 cycles. At edge 8: seg=19 for bcd=0x1234, scan_tick=1 for one cycle. an=1110 from edge 10.
- **Scan:** bcd=0x1234, blank_lz=0, dp_en=0. Required over one frame:
  - seg sequence 19, 30, 24, 79.
  - an sequence 1110, 1101, 1011, 0111, each low for 6 of 8 cycles and 1111 for the first 2.
  - dp=1 throughout.
- **Leading-zero blanking** (blank_lz=1):
  - bcd=0x0007 → digits 3..1 show 7F, digit 0 shows 78.
  - bcd=0x0000 → digit 0 shows 40, others 7F.
  - bcd=0x0102 → digit 3 shows 7F; digits 2, 1, 0 show 79, 40, 24.
- **Snapshot integrity:** bcd=0x1111, then change to 0x2222 during slot 1. Required: slots 2–3 of that frame still show 79; the next frame shows 24 on all digits. scan_tick pulses once every 32 cycles.
- **Invalid nibble and dp:** bcd=0xA5F0, dp_en=4'b0101. Required:
  - seg per digit 0..3: 40, 3F, 12, 3F.
  - dp=0 during slots 0 and 2, dp=1 during slots 1 and 3.
- **Mid-operation reset:** assert `grst` for 3 cycles mid-slot 2. Required: outputs reach reset values immediately. After release, the first tick comes after 8 cycles, and the scan resumes at digit 0 with a fresh snapshot.

Source files
------------

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if
//   Bundles the display-side signals of the seven-segment scanner.
//   master : the side that supplies digits and consumes segment drives
//   slave  : the scanner itself
//   bcd[15:0]  packed BCD {d3,d2,d1,d0}, d0 rightmost
//   dp_en[3:0] decimal-point enable per digit
//   blank_lz   leading-zero blanking enable
//   an[3:0]    anode selects, active-low
//   seg[6:0]   segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   scan_tick  one-cycle pulse at each frame start
interface seven_seg_scan_if;
  logic [15:0] bcd;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        scan_tick;

  modport master (
    output bcd, dp_en, blank_lz,
    input  an, seg, dp, scan_tick
  );

  modport slave (
    input  bcd, dp_en, blank_lz,
    output an, seg, dp, scan_tick
  );
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   One digit is shown per REFRESH_DIV-cycle slot; the first GUARD cycles of
//   every slot keep all anodes off. The BCD value and dp enables are captured
//   once per frame so a frame never mixes two input values.
//   clk  : system clock
//   grst : asynchronous active-high reset
//   disp : seven_seg_scan_if.slave (bcd/dp_en/blank_lz in, an/seg/dp/scan_tick out)
module seven_seg_scan #(
  parameter int REFRESH_DIV = 12500,
  parameter int GUARD       = 16
) (
  input  logic             clk,
  input  logic             grst,
  seven_seg_scan_if.slave  disp
);

  localparam int              PW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   PRES_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]   GUARD_V   = PW'(GUARD);

  // BCD digit to active-low segment pattern; non-BCD codes show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  logic [PW-1:0] pres_q, pres_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_bcd_q, snap_bcd_d;
  logic [3:0]    snap_dp_q, snap_dp_d;
  logic          started_q, started_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          scan_tick_q, scan_tick_d;

  logic          tick_s, wrap_s;
  logic [3:0]    digit_s;
  logic          blank3_s, blank2_s, blank1_s;
  logic [3:0]    blank_vec_s;

  // Next-state for the prescaler, digit index, snapshot and registered outputs.
  always_comb begin
    tick_s = (pres_q == PRES_LAST);
    wrap_s = tick_s && (idx_q == 2'd3);

    if (tick_s) begin
      pres_d = '0;
      idx_d  = idx_q + 2'd1;
    end else begin
      pres_d = pres_q + PW'(1);
      idx_d  = idx_q;
    end

    if (wrap_s) begin
      snap_bcd_d = disp.bcd;
      snap_dp_d  = disp.dp_en;
    end else begin
      snap_bcd_d = snap_bcd_q;
      snap_dp_d  = snap_dp_q;
    end

    // Anodes stay dark until the first slot after reset has actually begun.
    started_d = started_q | tick_s;

    case (idx_d)
      2'd0:    digit_s = snap_bcd_d[3:0];
      2'd1:    digit_s = snap_bcd_d[7:4];
      2'd2:    digit_s = snap_bcd_d[11:8];
      2'd3:    digit_s = snap_bcd_d[15:12];
      default: digit_s = 4'd0;
    endcase

    // blank_lz is live, but seg only updates on a tick, so a change lands
    // at the next slot boundary.
    blank3_s    = disp.blank_lz & (snap_bcd_d[15:12] == 4'd0);
    blank2_s    = blank3_s & (snap_bcd_d[11:8] == 4'd0);
    blank1_s    = blank2_s & (snap_bcd_d[7:4] == 4'd0);
    blank_vec_s = {blank3_s, blank2_s, blank1_s, 1'b0};

    if (tick_s) begin
      seg_d = blank_vec_s[idx_d] ? 7'h7F : bcd_to_seg(digit_s);
      dp_d  = ~snap_dp_d[idx_d];
    end else begin
      seg_d = seg_q;
      dp_d  = dp_q;
    end

    if (!started_d || (pres_d < GUARD_V)) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << idx_d);
    end

    scan_tick_d = wrap_s;
  end

  // State and output registers; reset forces the display dark immediately.
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      pres_q      <= '0;
      idx_q       <= 2'd3;
      snap_bcd_q  <= 16'h0000;
      snap_dp_q   <= 4'b0000;
      started_q   <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      scan_tick_q <= 1'b0;
    end else begin
      pres_q      <= pres_d;
      idx_q       <= idx_d;
      snap_bcd_q  <= snap_bcd_d;
      snap_dp_q   <= snap_dp_d;
      started_q   <= started_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      scan_tick_q <= scan_tick_d;
    end
  end

  assign disp.an        = an_q;
  assign disp.seg       = seg_q;
  assign disp.dp        = dp_q;
  assign disp.scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan
//   Directed bench for seven_seg_scan with REFRESH_DIV=8, GUARD=2.
//   Outputs are sampled on the falling clock edge.
module tb_seven_seg_scan;

  logic clk;
  logic grst;
  int   n_checks;
  int   n_fail;

  seven_seg_scan_if dif ();

  seven_seg_scan #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk  (clk),
    .grst (grst),
    .disp (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame of samples, index = cycle within the frame (slot*8 + pres).
  logic [3:0] an_s   [32];
  logic [6:0] seg_s  [32];
  logic       dp_s   [32];
  logic       tick_s [32];

  task automatic wait_frame_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.scan_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Records one frame; optionally drives a new bcd at cycle chg_at.
  task automatic capture_frame(input int chg_at, input logic [15:0] chg_val, output bit ok);
    wait_frame_start(ok);
    for (int c = 0; c < 32; c++) begin
      an_s[c]   = dif.an;
      seg_s[c]  = dif.seg;
      dp_s[c]   = dif.dp;
      tick_s[c] = dif.scan_tick;
      if (c == chg_at) dif.bcd = chg_val;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    grst = 1'b1;
    dif.bcd = 16'h1234;
    dif.dp_en = 4'b0000;
    dif.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dif.an !== 4'hF || dif.seg !== 7'h7F || dif.dp !== 1'b1 || dif.scan_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: an=%h seg=%h dp=%b tick=%b, required an=f seg=7f dp=1 tick=0",
               dif.an, dif.seg, dif.dp, dif.scan_tick);
    end
    grst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 7) begin
        n_checks++;
        if (dif.an !== 4'hF || dif.seg !== 7'h7F || dif.dp !== 1'b1 || dif.scan_tick !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_release_c%0d: an=%h seg=%h dp=%b tick=%b, required an=f seg=7f dp=1 tick=0",
                   k, dif.an, dif.seg, dif.dp, dif.scan_tick);
        end
      end else if (k == 8) begin
        n_checks++;
        if (dif.an !== 4'hF || dif.seg !== 7'h19 || dif.scan_tick !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_first_tick: an=%h seg=%h tick=%b, required an=f seg=19 tick=1",
                   dif.an, dif.seg, dif.scan_tick);
        end
      end else if (k == 9) begin
        n_checks++;
        if (dif.an !== 4'hF || dif.scan_tick !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_guard: an=%h tick=%b, required an=f tick=0", dif.an, dif.scan_tick);
        end
      end else begin
        n_checks++;
        if (dif.an !== 4'b1110 || dif.seg !== 7'h19) begin
          n_fail++;
          $display("FAIL reset_first_anode: an=%b seg=%h, required an=1110 seg=19", dif.an, dif.seg);
        end
      end
    end
  endtask

  task automatic test_scan;
    bit ok;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    int lows;
    exp_seg[0] = 7'h19; exp_seg[1] = 7'h30; exp_seg[2] = 7'h24; exp_seg[3] = 7'h79;
    dif.bcd = 16'h1234;
    dif.blank_lz = 1'b0;
    dif.dp_en = 4'b0000;
    capture_frame(-1, 16'h0000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL scan_timeout: scan_tick not seen within 40 cycles");
    end
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (seg_s[s*8+4] !== exp_seg[s]) begin
        n_fail++;
        $display("FAIL scan_seg_d%0d: got %h, required %h", s, seg_s[s*8+4], exp_seg[s]);
      end
      lows = 0;
      for (int o = 0; o < 8; o++) begin
        exp_an = (o < 2) ? 4'b1111 : ~(4'b0001 << s);
        if (an_s[s*8+o] != 4'b1111) lows++;
        n_checks++;
        if (an_s[s*8+o] !== exp_an || dp_s[s*8+o] !== 1'b1) begin
          n_fail++;
          $display("FAIL scan_an_s%0d_o%0d: an=%b dp=%b, required an=%b dp=1",
                   s, o, an_s[s*8+o], dp_s[s*8+o], exp_an);
        end
      end
      n_checks++;
      if (lows != 6) begin
        n_fail++;
        $display("FAIL scan_low_count_s%0d: got %0d, required 6", s, lows);
      end
    end
  endtask

  task automatic test_blanking;
    bit ok;
    logic [15:0] vec     [3];
    logic [6:0]  exp_seg [3][4];
    vec[0] = 16'h0007; exp_seg[0][0] = 7'h78; exp_seg[0][1] = 7'h7F; exp_seg[0][2] = 7'h7F; exp_seg[0][3] = 7'h7F;
    vec[1] = 16'h0000; exp_seg[1][0] = 7'h40; exp_seg[1][1] = 7'h7F; exp_seg[1][2] = 7'h7F; exp_seg[1][3] = 7'h7F;
    vec[2] = 16'h0102; exp_seg[2][0] = 7'h24; exp_seg[2][1] = 7'h40; exp_seg[2][2] = 7'h79; exp_seg[2][3] = 7'h7F;
    dif.blank_lz = 1'b1;
    for (int v = 0; v < 3; v++) begin
      dif.bcd = vec[v];
      capture_frame(-1, 16'h0000, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL blank_timeout_v%0d: scan_tick not seen", v);
      end
      for (int s = 0; s < 4; s++) begin
        n_checks++;
        if (seg_s[s*8+4] !== exp_seg[v][s]) begin
          n_fail++;
          $display("FAIL blank_%h_d%0d: got %h, required %h", vec[v], s, seg_s[s*8+4], exp_seg[v][s]);
        end
      end
    end
    dif.blank_lz = 1'b0;
  endtask

  task automatic test_snapshot;
    bit ok;
    dif.bcd = 16'h1111;
    capture_frame(10, 16'h2222, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL snap_timeout: scan_tick not seen");
    end
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (seg_s[s*8+4] !== 7'h79) begin
        n_fail++;
        $display("FAIL snap_old_d%0d: got %h, required 79", s, seg_s[s*8+4]);
      end
    end
    for (int c = 1; c < 32; c++) begin
      n_checks++;
      if (tick_s[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL snap_tick_gap_c%0d: got %b, required 0", c, tick_s[c]);
      end
    end
    // capture_frame left us exactly 32 cycles after the previous tick.
    n_checks++;
    if (dif.scan_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL snap_tick_period: scan_tick=%b at cycle 32, required 1", dif.scan_tick);
    end
    capture_frame(-1, 16'h0000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL snap_timeout2: scan_tick not seen");
    end
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (seg_s[s*8+4] !== 7'h24) begin
        n_fail++;
        $display("FAIL snap_new_d%0d: got %h, required 24", s, seg_s[s*8+4]);
      end
    end
  endtask

  task automatic test_invalid_dp;
    bit ok;
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];
    exp_seg[0] = 7'h40; exp_seg[1] = 7'h3F; exp_seg[2] = 7'h12; exp_seg[3] = 7'h3F;
    exp_dp[0] = 1'b0; exp_dp[1] = 1'b1; exp_dp[2] = 1'b0; exp_dp[3] = 1'b1;
    dif.bcd = 16'hA5F0;
    dif.dp_en = 4'b0101;
    capture_frame(-1, 16'h0000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL inv_timeout: scan_tick not seen");
    end
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (seg_s[s*8+4] !== exp_seg[s] || dp_s[s*8+1] !== exp_dp[s] || dp_s[s*8+6] !== exp_dp[s]) begin
        n_fail++;
        $display("FAIL inv_dp_d%0d: seg=%h dp=%b/%b, required seg=%h dp=%b",
                 s, seg_s[s*8+4], dp_s[s*8+1], dp_s[s*8+6], exp_seg[s], exp_dp[s]);
      end
    end
    dif.dp_en = 4'b0000;
  endtask

  task automatic test_mid_reset;
    bit ok;
    dif.bcd = 16'h1234;
    wait_frame_start(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mrst_timeout: scan_tick not seen");
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (dif.an !== 4'b1011 || dif.seg !== 7'h24) begin
      n_fail++;
      $display("FAIL mrst_pre: an=%b seg=%h, required an=1011 seg=24", dif.an, dif.seg);
    end
    grst = 1'b1;
    dif.bcd = 16'h5678;
    #1;
    n_checks++;
    if (dif.an !== 4'hF || dif.seg !== 7'h7F || dif.dp !== 1'b1 || dif.scan_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_async: an=%h seg=%h dp=%b tick=%b, required an=f seg=7f dp=1 tick=0",
               dif.an, dif.seg, dif.dp, dif.scan_tick);
    end
    repeat (3) @(negedge clk);
    grst = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k <= 7) begin
        n_checks++;
        if (dif.an !== 4'hF || dif.scan_tick !== 1'b0) begin
          n_fail++;
          $display("FAIL mrst_release_c%0d: an=%h tick=%b, required an=f tick=0", k, dif.an, dif.scan_tick);
        end
      end else if (k == 8) begin
        n_checks++;
        if (dif.scan_tick !== 1'b1 || dif.seg !== 7'h00) begin
          n_fail++;
          $display("FAIL mrst_first_tick: tick=%b seg=%h, required tick=1 seg=00", dif.scan_tick, dif.seg);
        end
      end else if (k == 10) begin
        n_checks++;
        if (dif.an !== 4'b1110) begin
          n_fail++;
          $display("FAIL mrst_digit0: an=%b, required 1110", dif.an);
        end
      end else if (k == 18) begin
        n_checks++;
        if (dif.an !== 4'b1101 || dif.seg !== 7'h78) begin
          n_fail++;
          $display("FAIL mrst_digit1: an=%b seg=%h, required an=1101 seg=78", dif.an, dif.seg);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    grst     = 1'b1;
    test_reset();
    test_scan();
    test_blanking();
    test_snapshot();
    test_invalid_dp();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
